// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a send/busy handshake.
//
// Ports
//   Clk, Reset       : system clock; asynchronous active-high reset
//   Wr_Data, Wr_En   : one byte enqueued per cycle while Wr_En=1
//   Full, Empty      : decoded from Count, valid in the same cycle as Count
//   Count            : bytes stored, 0..DEPTH
//   Overflow         : sticky, set when a write hits a full FIFO
//   Clr_Overflow     : synchronous clear of Overflow (a coincident drop wins)
//   Tx_Data, Tx_Send : byte and send request toward the transmitter
//   Tx_Busy          : transmitter busy status
module uart_tx_fifo #(
  parameter int AW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    Wr_Data,
  input  logic          Wr_En,
  output logic          Full,
  output logic          Empty,
  output logic [AW:0]   Count,
  output logic          Overflow,
  input  logic          Clr_Overflow,
  output logic [7:0]    Tx_Data,
  output logic          Tx_Send,
  input  logic          Tx_Busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          wr_acc, pop;

  assign Count   = count;
  assign Full    = (count == (AW+1)'(DEPTH));
  assign Empty   = (count == '0);
  // Full is the registered-count view, so a same-cycle pop never rescues a write.
  assign wr_acc  = Wr_En && !Full;
  assign Tx_Send = (state == S_SEND);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (!Empty && !Tx_Busy) begin
        pop       = 1'b1;
        state_nxt = S_SEND;
      end
      S_SEND: if (Tx_Busy)  state_nxt = S_WAIT;
      S_WAIT: if (!Tx_Busy) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Storage is left unreset; pointers and count define what is valid.
  always_ff @(posedge Clk) begin
    if (wr_acc) mem[wr_ptr] <= Wr_Data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Overflow <= 1'b0;
      Tx_Data  <= 8'h00;
    end else begin
      state <= state_nxt;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        Tx_Data <= mem[rd_ptr];
      end
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (Wr_En && Full)     Overflow <= 1'b1;
      else if (Clr_Overflow) Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard of expected transmitted bytes,
// a simple transmitter model, and immediate-assertion checks.
module tb_uart_tx_fifo;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Wr_Data = 8'h00;
  logic       Wr_En = 1'b0;
  logic       Full, Empty, Overflow, Tx_Send;
  logic [4:0] Count;
  logic       Clr_Overflow = 1'b0;
  logic [7:0] Tx_Data;
  logic       Tx_Busy;

  bit         model_en = 1'b0;
  logic       model_busy = 1'b0;
  logic       man_busy = 1'b0;
  int         busy_cnt = 0;
  logic       prev_send = 1'b0;
  int         n_sends = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb [$];

  assign Tx_Busy = model_en ? model_busy : man_busy;

  always #5 Clk = ~Clk;

  uart_tx_fifo #(.AW(4)) dut (
    .Clk(Clk), .Reset(Reset), .Wr_Data(Wr_Data), .Wr_En(Wr_En),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow),
    .Clr_Overflow(Clr_Overflow), .Tx_Data(Tx_Data), .Tx_Send(Tx_Send),
    .Tx_Busy(Tx_Busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit acc);
    Wr_Data = b;
    Wr_En   = 1'b1;
    if (acc) sb.push_back(b);
    tick();
    Wr_En   = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || Count != 0 || Tx_Send) && k < 3000) begin
      tick();
      k++;
    end
    check(tag, k < 3000, 1);
    repeat (16) tick();
  endtask

  // Monitor + transmitter model: each Tx_Send rise pops the scoreboard; the
  // model raises busy one cycle after the request and holds it 10 cycles.
  always @(negedge Clk) begin
    check("count_range", Count <= 5'd16, 1);
    if (Tx_Send && !prev_send) begin
      n_sends++;
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) check("tx_data", Tx_Data, sb.pop_front());
    end
    prev_send = Tx_Send;
    if (model_en) begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end else if (Tx_Send) begin
        model_busy = 1'b1;
        busy_cnt   = 10;
      end
    end else begin
      model_busy = 1'b0;
      busy_cnt   = 0;
    end
  end

  initial begin
    int base;
    logic [7:0] b;

    // reset state
    #1;
    check("rst_count", Count, 0);
    check("rst_empty", Empty, 1);
    check("rst_full", Full, 0);
    check("rst_ovf", Overflow, 0);
    check("rst_send", Tx_Send, 0);
    check("rst_data", Tx_Data, 8'h00);
    tick(); tick();
    Reset = 1'b0;
    tick();

    // single byte
    model_en = 1'b1;
    base = n_sends;
    wr(8'hA5, 1);
    check("single_no_early_send", Tx_Send, 0);
    check("single_count1", Count, 1);
    tick();
    check("single_send", Tx_Send, 1);
    check("single_data", Tx_Data, 8'hA5);
    check("single_count0", Count, 0);
    tick();
    check("single_send_drop", Tx_Send, 0);
    drain("single_drain");
    check("single_one_xfer", n_sends - base, 1);
    check("single_empty", Empty, 1);

    // fill with busy held
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'(i), i < 16);
    check("fill_count", Count, 16);
    check("fill_full", Full, 1);
    check("fill_ovf", Overflow, 1);
    check("fill_empty", Empty, 0);
    base = n_sends;
    man_busy = 1'b0;
    model_en = 1'b1;
    drain("fill_drain");
    check("fill_sends", n_sends - base, 16);
    check("fill_ovf_sticky", Overflow, 1);
    Clr_Overflow = 1'b1;
    tick();
    Clr_Overflow = 1'b0;
    check("ovf_clear", Overflow, 0);

    // simultaneous write and pop at Count=5
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 5; i++) wr(8'h20 + 8'(i), 1);
    check("c5_count", Count, 5);
    man_busy = 1'b0;
    wr(8'h55, 1);
    check("c5_wr_pop_count", Count, 5);
    check("c5_send", Tx_Send, 1);
    check("c5_data", Tx_Data, 8'h20);
    man_busy = 1'b1;
    tick();
    model_en = 1'b1;
    drain("c5_drain");

    // drop at full with same-cycle pop and Clr_Overflow: drop wins
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'h80 + 8'(i), 1);
    check("drop_full", Full, 1);
    man_busy = 1'b0;
    Clr_Overflow = 1'b1;
    wr(8'hEE, 0);
    Clr_Overflow = 1'b0;
    check("drop_ovf_set_wins", Overflow, 1);
    check("drop_count", Count, 15);
    check("drop_send", Tx_Send, 1);
    man_busy = 1'b1;
    tick();
    model_en = 1'b1;
    drain("drop_drain");
    Clr_Overflow = 1'b1;
    tick();
    Clr_Overflow = 1'b0;

    // wrap-around: 40 bytes in bursts of 4
    base = n_sends;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 4; j++) begin
        b = 8'($urandom);
        wr(b, 1);
      end
      repeat (60) tick();
    end
    drain("wrap_drain");
    check("wrap_sends", n_sends - base, 40);
    check("wrap_ovf", Overflow, 0);

    // busy already high when the first byte arrives
    model_en = 1'b0;
    man_busy = 1'b1;
    wr(8'h3C, 1);
    tick(); tick();
    check("busy_block_send", Tx_Send, 0);
    check("busy_block_count", Count, 1);
    man_busy = 1'b0;
    tick();
    check("busy_release_send", Tx_Send, 1);
    check("busy_release_data", Tx_Data, 8'h3C);
    man_busy = 1'b1;
    tick();
    check("busy_wait_send", Tx_Send, 0);
    man_busy = 1'b0;
    tick();
    check("busy_idle_gap", Tx_Send, 0);
    model_en = 1'b1;
    drain("busy_drain");

    // reset while in SEND with Count=3
    model_en = 1'b0;
    man_busy = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i), 1);
    man_busy = 1'b0;
    tick();
    check("rs_send", Tx_Send, 1);
    check("rs_count3", Count, 3);
    #2 Reset = 1'b1;
    #1;
    check("rs_async_send", Tx_Send, 0);
    check("rs_async_count", Count, 0);
    check("rs_async_empty", Empty, 1);
    check("rs_async_data", Tx_Data, 8'h00);
    check("rs_async_full", Full, 0);
    sb.delete();
    tick(); tick();
    Reset = 1'b0;
    model_en = 1'b1;
    base = n_sends;
    repeat (30) tick();
    check("rs_no_send", n_sends - base, 0);
    wr(8'h77, 1);
    drain("rs_drain");
    check("rs_new_send", n_sends - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
